// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The OVF signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             OVF;

  modport master (
    output start, A, B, Cin,
    input  busy, done, SUM, Cout, OVF
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, SUM, Cout, OVF
  );
`else
  modport master (
    output start, A, B, Cin,
    input  busy, done, SUM, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, SUM, Cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, registered carry, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output OVF.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;
  logic             accept;

  // Full-adder cell on the current LSBs.
  always_comb begin
    fa_s = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    fa_c = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  end

  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_s;
  end else begin : g_res_wn
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};
  end

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign accept   = ((state_q == StIdle) || (state_q == StDone)) && bus.start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = bus.start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      StShift: bus.busy = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state; results only move on the final shift edge.
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      op_a_d  = bus.A;
      op_b_d  = bus.B;
      carry_d = bus.Cin;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      res_d   = res_shift;
      op_a_d  = op_a_q >> 1;
      op_b_d  = op_b_q >> 1;
      carry_d = fa_c;
      cnt_d   = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d  = res_shift;
        cout_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_q is the carry into the MSB on this edge.
        ovf_d  = carry_q ^ fa_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.SUM  = sum_q;
  assign bus.Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a scoreboard of expected results.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge (the load edge); operands are scrambled afterwards.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit push);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = ci;
    if (push) sb.push_back(model(a, b, ci));
    tick();
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.Cin   = 1'($urandom);
  endtask

  // Waits (bounded) for done; reports cycles waited, busy cycles and whether SUM/Cout moved.
  task automatic wait_done(output int lat, output int busy_n, output bit overlap,
                           output bit moved);
    logic [W-1:0] s0;
    logic         c0;
    s0      = bus.SUM;
    c0      = bus.Cout;
    lat     = 0;
    busy_n  = 0;
    moved   = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.SUM !== s0 || bus.Cout !== c0) moved = 1'b1;
      tick();
      lat++;
    end
    overlap = (bus.busy === 1'b1) && (bus.done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++;
    if (bus.SUM !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h want 00", bus.SUM); end
    n_vec++;
    if (bus.Cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus.Cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_vec++;
    if (bus.OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.OVF); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int   lat, bn;
    bit   ov, mv;
    exp_t e;
    launch(8'h35, 8'h1A, 1'b0, 1'b1);
    wait_done(lat, bn, ov, mv);
    n_vec++;
    if (lat != 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_vec++;
    if (bn != 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
    n_vec++;
    if (ov) begin n_err++; $display("FAIL basic_busy_done_overlap: got 1 want 0"); end
    n_vec++;
    if (mv) begin n_err++; $display("FAIL basic_sum_stable: got moved want held"); end
    if (sb.size() == 0) begin
      n_vec++; n_err++; $display("FAIL basic_scoreboard: got empty want entry");
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.SUM !== e.sum) begin n_err++; $display("FAIL basic_sum: got %h want %h", bus.SUM, e.sum); end
      n_vec++;
      if (bus.Cout !== e.cout) begin n_err++; $display("FAIL basic_cout: got %b want %b", bus.Cout, e.cout); end
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] av[2] = '{8'hFF, 8'hFF};
    logic [W-1:0] bv[2] = '{8'h01, 8'hFF};
    logic         cv[2] = '{1'b0, 1'b1};
    int   lat, bn;
    bit   ov, mv;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      launch(av[i], bv[i], cv[i], 1'b1);
      wait_done(lat, bn, ov, mv);
      n_vec++;
      if (lat != 8) begin n_err++; $display("FAIL wrap%0d_latency: got %0d want 8", i, lat); end
      if (sb.size() == 0) begin
        n_vec++; n_err++; $display("FAIL wrap%0d_scoreboard: got empty want entry", i);
      end else begin
        e = sb.pop_front();
        n_vec++;
        if (bus.SUM !== e.sum) begin n_err++; $display("FAIL wrap%0d_sum: got %h want %h", i, bus.SUM, e.sum); end
        n_vec++;
        if (bus.Cout !== e.cout) begin n_err++; $display("FAIL wrap%0d_cout: got %b want %b", i, bus.Cout, e.cout); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int   lat, bn;
    bit   ov, mv;
    exp_t e;
    launch(8'h12, 8'h34, 1'b0, 1'b1);
    wait_done(lat, bn, ov, mv);
    n_vec++;
    if (lat != 8) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 8", lat); end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if (bus.SUM !== e.sum) begin n_err++; $display("FAIL b2b_first_sum: got %h want %h", bus.SUM, e.sum); end
    end
    // Still in the DONE cycle: present the next pair with start held.
    launch(8'h80, 8'h80, 1'b0, 1'b1);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL b2b_direct_load: got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    wait_done(lat, bn, ov, mv);
    n_vec++;
    if (lat != 8) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 8", lat); end
    n_vec++;
    if (mv) begin n_err++; $display("FAIL b2b_sum_stable: got moved want held"); end
    if (sb.size() == 0) begin
      n_vec++; n_err++; $display("FAIL b2b_scoreboard: got empty want entry");
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.SUM !== e.sum) begin n_err++; $display("FAIL b2b_second_sum: got %h want %h", bus.SUM, e.sum); end
      n_vec++;
      if (bus.Cout !== e.cout) begin n_err++; $display("FAIL b2b_second_cout: got %b want %b", bus.Cout, e.cout); end
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int   lat, bn, extra;
    bit   ov, mv;
    exp_t e;
    launch(8'h10, 8'h20, 1'b0, 1'b1);
    tick();
    tick();
    bus.start = 1'b1;
    bus.A     = 8'hAA;
    bus.B     = 8'h55;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bn, ov, mv);
    n_vec++;
    if (lat + 3 != 8) begin n_err++; $display("FAIL swb_latency: got %0d want 8", lat + 3); end
    if (sb.size() == 0) begin
      n_vec++; n_err++; $display("FAIL swb_scoreboard: got empty want entry");
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.SUM !== e.sum) begin n_err++; $display("FAIL swb_sum: got %h want %h", bus.SUM, e.sum); end
      n_vec++;
      if (bus.Cout !== e.cout) begin n_err++; $display("FAIL swb_cout: got %b want %b", bus.Cout, e.cout); end
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL swb_no_second_op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int   lat, bn;
    bit   ov, mv;
    exp_t e;
    launch(8'h55, 8'h66, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL rmid_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    n_vec++;
    if (bus.SUM !== 8'h00 || bus.Cout !== 1'b0) begin
      n_err++; $display("FAIL rmid_outputs: got sum=%h cout=%b want 00 0", bus.SUM, bus.Cout);
    end
    launch(8'h01, 8'h01, 1'b0, 1'b1);
    wait_done(lat, bn, ov, mv);
    n_vec++;
    if (lat != 8) begin n_err++; $display("FAIL rmid_latency: got %0d want 8", lat); end
    if (sb.size() == 0) begin
      n_vec++; n_err++; $display("FAIL rmid_scoreboard: got empty want entry");
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bus.SUM !== e.sum) begin n_err++; $display("FAIL rmid_sum: got %h want %h", bus.SUM, e.sum); end
    end
    tick();
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] av[2] = '{8'h7F, 8'hFF};
    logic [W-1:0] bv[2] = '{8'h01, 8'h01};
    int   lat, bn;
    bit   ov, mv;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      launch(av[i], bv[i], 1'b0, 1'b1);
      wait_done(lat, bn, ov, mv);
      if (sb.size() == 0) begin
        n_vec++; n_err++; $display("FAIL ovf%0d_scoreboard: got empty want entry", i);
      end else begin
        e = sb.pop_front();
        n_vec++;
        if (bus.SUM !== e.sum) begin n_err++; $display("FAIL ovf%0d_sum: got %h want %h", i, bus.SUM, e.sum); end
        n_vec++;
        if (bus.OVF !== e.ovf) begin n_err++; $display("FAIL ovf%0d_ovf: got %b want %b", i, bus.OVF, e.ovf); end
        n_vec++;
        if (bus.Cout !== e.cout) begin n_err++; $display("FAIL ovf%0d_cout: got %b want %b", i, bus.Cout, e.cout); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around one full-adder cell and a registered carry. It adds two WIDTH-bit operands LSB first, one bit per clock.
- Sits downstream of the combinational full adder. It consumes that adder's SUM/Cout each cycle, feeds Cout back as the next Cin, and shifts SUM into a result register.
- Start/busy/done handshake toward the control logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal values 1 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only when accepting (see Behaviour).
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  initial carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse; SUM/Cout are valid from this cycle on.
- SUM  output  WIDTH  registered result, held until the next completion.
- Cout  output  1  registered final carry-out, held until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst=1 at an edge): state=IDLE; busy=0, done=0, SUM=0, Cout=0; internal shift registers, carry register and bit counter all 0. Reset has priority over every other input.
- States: IDLE, SHIFT, DONE.
- Accepting states are IDLE and DONE. An edge with start=1 in either one is the load edge t0:
  - opA<=A, opB<=B, carry<=Cin, cnt<=0, next state SHIFT.
  - Operands are not sampled again; A/B/Cin may change after t0.
- SHIFT, one bit per edge:
  - s = opA[0]^opB[0]^carry and c = majority(opA[0],opB[0],carry), from the full-adder cell.
  - res <= {s, res[WIDTH-1:1]}; opA and opB shift right by 1; carry <= c; cnt++.
- SHIFT exit: on the edge where cnt==WIDTH-1 (edge t0+WIDTH):
  - SUM <= final res including the last bit, so SUM[i] is bit i of A+B+Cin.
  - Cout <= c; next state DONE.
- DONE: done=1 for exactly one cycle. Without start it returns to IDLE; with start=1 it goes straight to SHIFT (back-to-back operation).
- busy = 1 exactly while state==SHIFT.
- Latency: done is high in the cycle after edge t0+WIDTH, i.e. WIDTH cycles after the load edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy is ignored. There is no queueing and in-flight operands are not disturbed.
- WIDTH=1: SHIFT lasts one cycle; done follows the load by 1 cycle.
- Wrap-around: SUM is (A+B+Cin) mod 2^WIDTH. Cout is bit WIDTH of the true sum.
- Reset mid-operation (rst during SHIFT): the operation is aborted and all outputs are 0 the next cycle. A subsequent start behaves normally.
- SUM and Cout change only on completion edges and on reset. They are stable in IDLE and SHIFT.
- done and busy are never both 1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port OVF (output, 1 bit): signed two's-complement overflow, equal to (carry into MSB) XOR (carry out of MSB).
  - OVF is captured on the completion edge, has reset value 0, and holds like SUM.
- Undefined: the OVF port and its logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8.
1. Basic add: A=8'h35, B=8'h1A, Cin=0, start pulsed for 1 cycle -> busy=1 for 8 cycles; done=1 exactly 8 cycles after the load edge; SUM=8'h4F, Cout=0.
2. Wrap and carry: A=8'hFF, B=8'h01, Cin=0 -> SUM=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 -> SUM=8'hFF, Cout=1.
3. Start while busy: start A=8'h10, B=8'h20; at cycle 3 assert start with A=8'hAA, B=8'h55 -> second start ignored; result SUM=8'h30, Cout=0; exactly one done pulse.
4. Back-to-back: hold start=1 with a new operand pair presented in the DONE cycle (A=8'h80, B=8'h80) -> the next operation loads without passing through IDLE; SUM=8'h00, Cout=1, done 8 cycles later.
5. Reset mid-operation: assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, SUM=0, Cout=0. Then A=8'h01, B=8'h01 -> SUM=8'h02.
6. With SERIAL_ADDER_OVF_EN: A=8'h7F, B=8'h01 -> SUM=8'h80, OVF=1, Cout=0. A=8'hFF, B=8'h01 -> OVF=0, Cout=1.
